// File: rtl/snake_body_buffer_if.sv
// rtl/snake_body_buffer_if.sv - step/erase/collision/read bus of the snake body buffer
interface snake_body_buffer_if #(
  parameter int MAXLEN = 16,
  parameter int LW     = $clog2(MAXLEN + 1),
  parameter int IW     = $clog2(MAXLEN)
);
  logic          init;
  logic          step;
  logic          grow;
  logic [7:0]    head_x;
  logic [6:0]    head_y;
  logic          ready;
  logic          erase_valid;
  logic [7:0]    erase_x;
  logic [6:0]    erase_y;
  logic          col_done;
  logic          col_hit;
  logic [LW-1:0] len;
  logic          full;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_x;
  logic [6:0]    rd_y;
  logic          rd_in;

  // Movement / draw FSM side.
  modport master (
    output init, step, grow, head_x, head_y, rd_idx,
    input  ready, erase_valid, erase_x, erase_y, col_done, col_hit,
           len, full, rd_x, rd_y, rd_in
  );

  // Buffer side.
  modport slave (
    input  init, step, grow, head_x, head_y, rd_idx,
    output ready, erase_valid, erase_x, erase_y, col_done, col_hit,
           len, full, rd_x, rd_y, rd_in
  );
endinterface

// File: rtl/snake_body_buffer.sv
// rtl/snake_body_buffer.sv - snake segment store with tail erase, self-collision scan and read port
module snake_body_buffer #(
  parameter int         MAXLEN  = 16,
  parameter int         INITLEN = 3,
  parameter logic [7:0] X0      = 8'd39,
  parameter logic [6:0] Y0      = 7'd59,
  parameter int         CELL    = 10,
  parameter int         LW      = $clog2(MAXLEN + 1),
  parameter int         IW      = $clog2(MAXLEN)
) (
  input logic                CLOCK_50,
  input logic                Resetn,
  snake_body_buffer_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    seg_x [MAXLEN];
  logic [6:0]    seg_y [MAXLEN];
  logic [LW-1:0] len_q;
  logic [IW-1:0] k_q;
  logic          col_hit_q, col_done_q;
  logic          erase_valid_q;
  logic [7:0]    erase_x_q;
  logic [6:0]    erase_y_q;
  logic [7:0]    rd_x_q;
  logic [6:0]    rd_y_q;
  logic          rd_in_q;
  logic          accept, scan_hit, scan_last;
  logic [IW-1:0] tail_idx;

  // Slot holding the current tail; only meaningful while len > 0.
  assign tail_idx = IW'(len_q - LW'(1));

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Step acceptance and one-compare-per-cycle scan decisions; init overrides all.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    scan_hit  = 1'b0;
    scan_last = 1'b0;
    case (state)
      IDLE: begin
        if (bus.step && len_q != '0) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (seg_x[k_q] == seg_x[0] && seg_y[k_q] == seg_y[0]) begin
          scan_hit  = 1'b1;
          state_nxt = IDLE;
        end else if (LW'(k_q) == len_q - LW'(1)) begin
          scan_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.init) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      scan_hit  = 1'b0;
      scan_last = 1'b0;
    end
  end

  // Segment array, length, erase report, collision flags and registered read port.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      for (int i = 0; i < MAXLEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      len_q         <= '0;
      k_q           <= '0;
      col_hit_q     <= 1'b0;
      col_done_q    <= 1'b0;
      erase_valid_q <= 1'b0;
      erase_x_q     <= '0;
      erase_y_q     <= '0;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      rd_in_q       <= 1'b0;
    end else begin
      erase_valid_q <= 1'b0;
      col_done_q    <= 1'b0;
      // Reads see the contents before any update on this same edge.
      rd_x_q  <= seg_x[bus.rd_idx];
      rd_y_q  <= seg_y[bus.rd_idx];
      rd_in_q <= (LW'(bus.rd_idx) < len_q);
      if (bus.init) begin
        for (int i = 0; i < MAXLEN; i++) begin
          if (i < INITLEN) begin
            seg_x[i] <= X0 - 8'(i * CELL);
            seg_y[i] <= Y0;
          end else begin
            seg_x[i] <= '0;
            seg_y[i] <= '0;
          end
        end
        len_q     <= LW'(INITLEN);
        col_hit_q <= 1'b0;
      end else if (accept) begin
        for (int i = 1; i < MAXLEN; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0]  <= bus.head_x;
        seg_y[0]  <= bus.head_y;
        col_hit_q <= 1'b0;
        k_q       <= IW'(1);
        if (bus.grow && len_q != LW'(MAXLEN)) begin
          len_q <= len_q + LW'(1);
        end else begin
          erase_x_q     <= seg_x[tail_idx];
          erase_y_q     <= seg_y[tail_idx];
          erase_valid_q <= 1'b1;
        end
      end else if (scan_hit) begin
        col_hit_q  <= 1'b1;
        col_done_q <= 1'b1;
      end else if (scan_last) begin
        col_done_q <= 1'b1;
      end else if (state == SCAN) begin
        k_q <= k_q + IW'(1);
      end
    end
  end

  assign bus.ready       = (state == IDLE) && (len_q != '0);
  assign bus.erase_valid = erase_valid_q;
  assign bus.erase_x     = erase_x_q;
  assign bus.erase_y     = erase_y_q;
  assign bus.col_done    = col_done_q;
  assign bus.col_hit     = col_hit_q;
  assign bus.len         = len_q;
  assign bus.full        = (len_q == LW'(MAXLEN));
  assign bus.rd_x        = rd_x_q;
  assign bus.rd_y        = rd_y_q;
  assign bus.rd_in       = rd_in_q;

endmodule

// File: tb/tb_snake_body_buffer.sv
// tb/tb_snake_body_buffer.sv - randomized self-checking bench for snake_body_buffer
module tb_snake_body_buffer;
  localparam int MAXLEN  = 16;
  localparam int INITLEN = 3;
  localparam int LW      = 5;
  localparam int IW      = 4;

  logic CLOCK_50 = 1'b0;
  logic Resetn   = 1'b0;
  int   tests    = 0;
  int   fails    = 0;

  // Spec-level model: all MAXLEN slots, head first, plus the length.
  logic [7:0] mx [$];
  logic [6:0] my [$];
  int         mlen;

  snake_body_buffer_if #(.MAXLEN(MAXLEN), .LW(LW), .IW(IW)) bus ();

  snake_body_buffer #(.MAXLEN(MAXLEN), .INITLEN(INITLEN)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic cyc();
    @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx.delete(); my.delete();
    for (int i = 0; i < MAXLEN; i++) begin mx.push_back(8'd0); my.push_back(7'd0); end
    mlen = 0;
  endtask

  task automatic model_init();
    for (int i = 0; i < MAXLEN; i++) begin
      mx[i] = (i < INITLEN) ? 8'(39 - 10 * i) : 8'd0;
      my[i] = (i < INITLEN) ? 7'd59 : 7'd0;
    end
    mlen = INITLEN;
  endtask

  task automatic pulse_init();
    bus.init = 1'b1;
    cyc();
    bus.init = 1'b0;
    model_init();
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < MAXLEN; i++) begin
      bus.rd_idx = IW'(i);
      cyc();
      chk($sformatf("%s_rd%0d", tag, i), {bus.rd_in, bus.rd_y, bus.rd_x},
          {(i < mlen) ? 1'b1 : 1'b0, my[i], mx[i]});
    end
  endtask

  // One accepted step; poke=1 also drives a stray step during the scan.
  task automatic do_step(input string tag, input logic [7:0] hx, input logic [6:0] hy,
                         input logic g, input int poke);
    int         r, exp_k, n, bad, hitk;
    logic       exp_er, done;
    logic [7:0] ex, px;
    logic [6:0] ey, py;
    logic       pin;
    r   = $urandom_range(MAXLEN - 1);
    px  = mx[r]; py = my[r]; pin = (r < mlen);
    exp_er = !(g && mlen < MAXLEN);
    ex  = mx[mlen-1]; ey = my[mlen-1];
    mx.push_front(hx); my.push_front(hy);
    void'(mx.pop_back()); void'(my.pop_back());
    if (!exp_er) mlen++;
    hitk = 0;
    for (int i = mlen - 1; i >= 1; i--) if (mx[i] == hx && my[i] == hy) hitk = i;
    exp_k = (hitk != 0) ? hitk : mlen - 1;

    bus.rd_idx = IW'(r);
    bus.head_x = hx; bus.head_y = hy; bus.grow = g; bus.step = 1'b1;
    cyc();
    bus.step = 1'b0; bus.grow = 1'b0;
    chk({tag, "_erase_valid"}, bus.erase_valid, exp_er);
    if (exp_er) chk({tag, "_erase_xy"}, {bus.erase_x, bus.erase_y}, {ex, ey});
    chk({tag, "_len"}, bus.len, mlen);
    chk({tag, "_full"}, bus.full, (mlen == MAXLEN));
    chk({tag, "_hit_clr"}, bus.col_hit, 1'b0);
    chk({tag, "_ready_lo"}, bus.ready, 1'b0);
    chk({tag, "_rd_pre"}, {bus.rd_in, bus.rd_y, bus.rd_x}, {pin, py, px});
    if (poke == 1) begin
      bus.step = 1'b1; bus.grow = 1'b1;
      bus.head_x = 8'($urandom); bus.head_y = 7'($urandom);
    end
    n = 0; bad = 0; done = 1'b0;
    while (!done && n < MAXLEN + 2) begin
      cyc();
      n++;
      bus.step = 1'b0; bus.grow = 1'b0;
      if (n == 1 && bus.erase_valid) bad++;
      if (bus.col_done) done = 1'b1;
      else if (bus.ready) bad++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_done_lat"}, n, exp_k);
    chk({tag, "_hit"}, bus.col_hit, (hitk != 0));
    chk({tag, "_scan_quiet"}, bad, 0);
    chk({tag, "_ready_hi"}, bus.ready, 1'b1);
    cyc();
    chk({tag, "_done_1cyc"}, bus.col_done, 1'b0);
    chk({tag, "_len_hold"}, bus.len, mlen);
  endtask

  initial begin
    int         seen;
    logic [7:0] rx;
    logic [6:0] ry;
    bus.init = 1'b0; bus.step = 1'b0; bus.grow = 1'b0;
    bus.head_x = '0; bus.head_y = '0; bus.rd_idx = '0;
    model_reset();
    repeat (3) cyc();
    chk("rst_outs", {bus.ready, bus.erase_valid, bus.erase_x, bus.erase_y, bus.col_done,
                     bus.col_hit, bus.len, bus.full, bus.rd_x, bus.rd_y, bus.rd_in}, '0);
    Resetn = 1'b1;
    cyc();
    read_all("rst");
    // step with len=0 is ignored
    bus.step = 1'b1; bus.head_x = 8'd5; cyc(); bus.step = 1'b0;
    chk("len0_step_len", bus.len, 0);
    chk("len0_step_erase", bus.erase_valid, 1'b0);

    pulse_init();
    chk("init_len", bus.len, 3);
    chk("init_full", bus.full, 1'b0);
    chk("init_ready", bus.ready, 1'b1);
    read_all("init");

    do_step("s49", 8'd49, 7'd59, 1'b0, 0);
    read_all("s49");

    pulse_init();
    do_step("g49", 8'd49, 7'd69, 1'b1, 0);
    chk("g49_seg3", {mx[3], my[3]}, {8'd19, 7'd59});
    read_all("g49");

    // grow to full, then grow while full
    for (int i = 0; i < 12; i++) do_step("grow", 8'($urandom), 7'($urandom), 1'b1, 0);
    chk("full_len", bus.len, MAXLEN);
    chk("full_flag", bus.full, 1'b1);
    do_step("gfull", 8'($urandom), 7'($urandom), 1'b1, 0);
    read_all("gfull");

    // directed collision on a length-5 body
    pulse_init();
    do_step("c1", 8'd100, 7'd10, 1'b1, 0);
    do_step("c2", 8'd110, 7'd20, 1'b1, 0);
    do_step("chit", mx[3], my[3], 1'b0, 0);
    chk("chit_flag", bus.col_hit, 1'b1);
    do_step("cclr", 8'd200, 7'd100, 1'b0, 0);

    // stray step during scan
    do_step("poke", 8'd201, 7'd101, 1'b0, 1);
    read_all("poke");

    // randomized steps, biased toward collisions
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(2) == 0) begin
        int j;
        j  = $urandom_range(mlen - 1);
        rx = mx[j]; ry = my[j];
      end else begin
        rx = 8'($urandom_range(7)); ry = 7'($urandom_range(3));
      end
      do_step("rnd", rx, ry, 1'($urandom), (i % 7 == 3) ? 1 : 0);
    end
    read_all("rnd");

    // init and step in the same cycle: init wins
    bus.init = 1'b1; bus.step = 1'b1; bus.head_x = 8'd77; bus.head_y = 7'd7;
    cyc();
    bus.init = 1'b0; bus.step = 1'b0;
    model_init();
    chk("initstep_erase", bus.erase_valid, 1'b0);
    chk("initstep_ready", bus.ready, 1'b1);
    read_all("initstep");

    // init mid-scan: no col_done pulse
    bus.step = 1'b1; bus.head_x = 8'd90; bus.head_y = 7'd90;
    cyc();
    bus.step = 1'b0;
    pulse_init();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.col_done) seen++;
      cyc();
    end
    chk("initabort_nodone", seen, 0);
    chk("initabort_len", bus.len, INITLEN);
    chk("initabort_ready", bus.ready, 1'b1);
    read_all("initabort");

    // reset mid-scan
    bus.step = 1'b1; bus.head_x = 8'd91; bus.head_y = 7'd91; bus.rd_idx = '0;
    cyc();
    bus.step = 1'b0;
    Resetn = 1'b0;
    cyc();
    chk("rstscan_outs", {bus.ready, bus.erase_valid, bus.erase_x, bus.erase_y, bus.col_done,
                         bus.col_hit, bus.len, bus.full, bus.rd_x, bus.rd_y, bus.rd_in}, '0);
    Resetn = 1'b1;
    model_reset();
    read_all("rstscan");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
